// File: rtl/mult_pkg.sv
// Shared types and constants for the iterative carry-save multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mult_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_PW    = 2 * DEFAULT_WIDTH;

    // Sequencer states; 2-bit encoding keeps the state register minimal.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Product width for a given operand width.
    function automatic int pw_of(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/csa_row.sv
// 3:2 carry-save compressor row: folds three W-bit vectors into a (sum, carry) pair.
// Latency: purely combinational.
// Backpressure: none; no handshake at this level.
module csa_row #(
    parameter int W = 64
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] z,
    output logic [W-1:0] s,
    output logic [W-1:0] c
);

    // Majority of the low W-1 bits only: the carry out of the top bit is dropped.
    logic [W-2:0] maj;

    assign s   = x ^ y ^ z;
    assign maj = (x[W-2:0] & y[W-2:0]) | (x[W-2:0] & z[W-2:0]) | (y[W-2:0] & z[W-2:0]);
    assign c   = {maj, 1'b0};

endmodule

// File: rtl/csa_mult_sequencer.sv
// Iterative unsigned WIDTH x WIDTH multiplier: one CSA row per multiplier bit, then one CPA.
// Latency: accept at edge k -> out_valid from cycle k+N+2 (N = WIDTH, or msb(b)+1 with early exit).
// Backpressure: in_ready only in IDLE; DONE holds out_p/out_valid until out_ready.
module csa_mult_sequencer
    import mult_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
    output logic                 busy
);

    localparam int PW = pw_of(WIDTH);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t          state_q;
    logic [PW-1:0]   a_q;
    logic [WIDTH-1:0] b_q;
    logic [PW-1:0]   sum_q;
    logic [PW-1:0]   carry_q;
    logic [CW-1:0]   cnt_q;
    logic [PW-1:0]   p_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            busy_q;

    logic [PW-1:0]   pp_d;
    logic [PW-1:0]   sum_d;
    logic [PW-1:0]   carry_d;
    logic            last_d;

    // Partial product for the current multiplier bit, and the exit condition for ACCUM.
    assign pp_d   = b_q[0] ? a_q : '0;
    assign last_d = (cnt_q == CNT_LAST) || (EARLY_EXIT && ((b_q >> 1) == '0));

    csa_row #(.W(PW)) u_csa_row (
        .x (sum_q),
        .y (carry_q),
        .z (pp_d),
        .s (sum_d),
        .c (carry_d)
    );

    // Sequencer FSM with datapath registers; handshake outputs are registered alongside state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= '0;
            cnt_q       <= '0;
            p_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= {{WIDTH{1'b0}}, in_a};
                        b_q        <= in_b;
                        sum_q      <= '0;
                        carry_q    <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ACCUM;
                    end
                end
                ACCUM: begin
                    sum_q   <= sum_d;
                    carry_q <= carry_d;
                    a_q     <= a_q << 1;
                    b_q     <= b_q >> 1;
                    cnt_q   <= cnt_q + CW'(1);
                    if (last_d) begin
                        state_q <= FINAL;
                    end
                end
                FINAL: begin
                    // Carry-out of the PW-bit add is discarded; a*b always fits in PW bits.
                    p_q         <= sum_q + carry_q;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_p     = p_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_csa_mult_sequencer.sv
// Bench for csa_mult_sequencer: one instance per EARLY_EXIT value behind a shared stimulus mux.
// Latency: scoreboard checks product and accept-to-valid latency for every job.
// Backpressure: directed out_ready hold plus random out_ready soak.
module tb_csa_mult_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;          // 0: EARLY_EXIT=0 instance, 1: EARLY_EXIT=1 instance
    logic        in_valid;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        rdy_force;
    logic        rand_rdy;
    logic        rnd_bit;
    logic        out_ready;

    logic        in_valid0, in_ready0, out_valid0, busy0;
    logic        in_valid1, in_ready1, out_valid1, busy1;
    logic [63:0] out_p0, out_p1;
    logic        in_ready, out_valid, busy;
    logic [63:0] out_p;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [63:0] exp_p_q[$];
    int          exp_lat_q[$];
    logic        pending = 1'b0;
    logic        seen_valid = 1'b0;
    int          acc_cyc = 0;

    always #5 clk = ~clk;

    assign out_ready = rand_rdy ? rnd_bit : rdy_force;
    assign in_valid0 = in_valid & ~sel;
    assign in_valid1 = in_valid & sel;
    assign in_ready  = sel ? in_ready1  : in_ready0;
    assign out_valid = sel ? out_valid1 : out_valid0;
    assign busy      = sel ? busy1      : busy0;
    assign out_p     = sel ? out_p1     : out_p0;

    csa_mult_sequencer #(.WIDTH(32), .EARLY_EXIT(1'b0)) u_dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid0),
        .in_ready  (in_ready0),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid0),
        .out_ready (out_ready),
        .out_p     (out_p0),
        .busy      (busy0)
    );

    csa_mult_sequencer #(.WIDTH(32), .EARLY_EXIT(1'b1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .out_p     (out_p1),
        .busy      (busy1)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference iteration count: full width, or index of the top set bit of b plus one.
    function automatic int model_n(input logic [31:0] b, input logic ee);
        int n;
        if (!ee) return 32;
        n = 1;
        for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
        return n;
    endfunction

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rnd_bit <= 1'($urandom_range(0, 1));
    end

    // Scoreboard monitor: push on accept, check latency on first valid, pop on output handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            pending    = 1'b0;
            seen_valid = 1'b0;
            exp_p_q.delete();
            exp_lat_q.delete();
        end else begin
            if (pending) begin
                check_eq("in_ready_busy", 64'(in_ready), 64'd0);
                check_eq("busy_hi", 64'(busy), 64'd1);
            end else begin
                check_eq("in_ready_idle", 64'(in_ready), 64'd1);
                check_eq("busy_lo", 64'(busy), 64'd0);
                check_eq("out_valid_idle", 64'(out_valid), 64'd0);
            end
            if (out_valid && !seen_valid) begin
                seen_valid = 1'b1;
                check_eq("lat_expected", 64'(exp_lat_q.size() != 0), 64'd1);
                if (exp_lat_q.size() != 0)
                    check_eq("latency", 64'(cyc + 1 - acc_cyc), 64'(exp_lat_q[0]));
            end
            if (out_valid && out_ready) begin
                check_eq("out_expected", 64'(exp_p_q.size() != 0), 64'd1);
                if (exp_p_q.size() != 0) begin
                    check_eq("product", out_p, exp_p_q.pop_front());
                    void'(exp_lat_q.pop_front());
                end
                pending    = 1'b0;
                seen_valid = 1'b0;
            end
            if (in_valid && in_ready) begin
                exp_p_q.push_back({32'd0, in_a} * {32'd0, in_b});
                exp_lat_q.push_back(model_n(in_b, sel) + 2);
                acc_cyc = cyc + 1;
                pending = 1'b1;
            end
        end
    end

    // Present one operand pair and hold it until accepted.
    task automatic send(input logic [31:0] a, input logic [31:0] b);
        logic ok;
        ok       = 1'b0;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_eq("send_timeout", 64'(ok), 64'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 600 && pending; i++) @(negedge clk);
        check_eq("idle_timeout", 64'(pending), 64'd0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] exp_bp;
        logic        ok;
        rst_n     = 1'b0;
        sel       = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        rdy_force = 1'b1;
        rand_rdy  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_in_ready0", 64'(in_ready0), 64'd1);
        check_eq("rst_out_valid0", 64'(out_valid0), 64'd0);
        check_eq("rst_busy0", 64'(busy0), 64'd0);
        check_eq("rst_out_p0", out_p0, 64'd0);
        check_eq("rst_in_ready1", 64'(in_ready1), 64'd1);
        check_eq("rst_out_p1", out_p1, 64'd0);
        @(posedge clk);
        #1;

        // Full-width iterations, including all-ones operands.
        sel = 1'b0;
        send(32'd3, 32'd5);
        wait_idle();
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle();
        check_eq("allones_p", out_p, 64'hFFFF_FFFE_0000_0001);

        // Early exit: zero multiplier and a single high bit.
        @(posedge clk);
        #1;
        sel = 1'b1;
        send(32'h1234_5678, 32'd0);
        wait_idle();
        check_eq("zero_b_p", out_p, 64'd0);
        send(32'd7, 32'h10);
        wait_idle();
        check_eq("b10_p", out_p, 64'h70);

        // Back-pressure: hold DONE for 10 cycles while poking the input side.
        @(posedge clk);
        #1;
        sel       = 1'b0;
        rdy_force = 1'b0;
        exp_bp    = {32'd0, 32'hDEAD_BEEF} * {32'd0, 32'h1234_5678};
        send(32'hDEAD_BEEF, 32'h1234_5678);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (out_valid) ok = 1'b1;
        end
        check_eq("bp_valid_timeout", 64'(ok), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            in_a     = $urandom;
            in_b     = $urandom;
            in_valid = 1'(i % 2);
            @(negedge clk);
            check_eq("bp_out_p", out_p, exp_bp);
            check_eq("bp_out_valid", 64'(out_valid), 64'd1);
            check_eq("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        rdy_force = 1'b1;
        wait_idle();

        // Reset in the middle of ACCUM (cnt == 10) aborts the job.
        @(posedge clk);
        #1;
        send(32'hCAFE_F00D, 32'h8765_4321);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("midrst_in_ready", 64'(in_ready), 64'd1);
        check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
        check_eq("midrst_busy", 64'(busy), 64'd0);
        check_eq("midrst_out_p", out_p, 64'd0);
        @(posedge clk);
        #1;
        send(32'd2, 32'd9);
        wait_idle();
        check_eq("post_rst_p", out_p, 64'h12);

        // Random soak on both instances with random out_ready.
        rand_rdy = 1'b1;
        sel      = 1'b0;
        for (int i = 0; i < 800; i++) begin
            send($urandom, $urandom);
        end
        wait_idle();
        @(posedge clk);
        #1;
        sel = 1'b1;
        for (int i = 0; i < 1200; i++) begin
            send($urandom, $urandom >> $urandom_range(0, 31));
        end
        wait_idle();
        check_eq("scoreboard_empty", 64'(exp_p_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
